// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants, state encoding and LM/SM opcodes for the load/store-multiple sequencer.
package lmsm_sequencer_pkg;

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 16;
  localparam int unsigned RW   = 3;
  localparam int unsigned CW   = RW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Main-controller opcodes that raise start
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Request / memory / register-file steering bundle between controller, datapath and sequencer.
interface lmsm_sequencer_if;
  import lmsm_sequencer_pkg::*;

  logic            start;
  logic            is_store;
  logic [NREG-1:0] reg_mask;
  logic [AW-1:0]   base_addr;
  logic            mem_ack;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [RW-1:0]   rf_raddr;
  logic [RW-1:0]   rf_waddr;
  logic            rf_wen;
  logic            busy;
  logic            done;
  logic [CW-1:0]   reg_count;

  modport master (
    output start, is_store, reg_mask, base_addr, mem_ack,
    input  mem_addr, mem_rd, mem_wr, rf_raddr, rf_waddr, rf_wen, busy, done, reg_count
  );

  modport slave (
    input  start, is_store, reg_mask, base_addr, mem_ack,
    output mem_addr, mem_rd, mem_wr, rf_raddr, rf_waddr, rf_wen, busy, done, reg_count
  );

endinterface

// File: rtl/lmsm_sequencer_prio_enc_lsb.sv
// Lowest-set-bit priority encoder over the remaining register mask.
module prio_enc_lsb
  import lmsm_sequencer_pkg::*;
(
  input  logic [NREG-1:0] mask_i,
  output logic [RW-1:0]   index_o,
  output logic            valid_o
);

  // Descending scan so the lowest set bit is the last (winning) assignment
  always_comb begin
    index_o = '0;
    valid_o = |mask_i;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_i[i]) index_o = RW'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks the latched register mask lowest-first, one memory access per selected register.
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  lmsm_sequencer_if.slave   bus
);

  state_e          state_q;
  logic [NREG-1:0] mask_q;
  logic [NREG-1:0] mask_d;
  logic [AW-1:0]   addr_q;
  logic [CW-1:0]   count_q;
  logic            store_q;
  logic [RW-1:0]   idx;
  logic            idx_valid;
  logic            act;

  prio_enc_lsb u_enc (
    .mask_i  (mask_q),
    .index_o (idx),
    .valid_o (idx_valid)
  );

  // Remaining mask with its lowest set bit cleared
  assign mask_d = mask_q & (mask_q - NREG'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      store_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mask_q  <= bus.reg_mask;
            addr_q  <= bus.base_addr;
            store_q <= bus.is_store;
            count_q <= '0;
            state_q <= (bus.reg_mask != '0) ? ST_XFER : ST_DONE;
          end
        end
        ST_XFER: begin
          if (bus.mem_ack) begin
            mask_q  <= mask_d;
            addr_q  <= addr_q + AW'(1);
            count_q <= count_q + CW'(1);
            if (mask_d == '0) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Steering is only live in XFER and is forced quiet while reset is held
  assign act = (state_q == ST_XFER) && idx_valid && !reset;

  assign bus.mem_addr  = act ? addr_q : '0;
  assign bus.mem_rd    = act && !store_q;
  assign bus.mem_wr    = act && store_q;
  assign bus.rf_raddr  = act ? idx : '0;
  assign bus.rf_waddr  = act ? idx : '0;
  assign bus.rf_wen    = act && !store_q && bus.mem_ack;
  assign bus.busy      = (state_q != ST_IDLE) && !reset;
  assign bus.done      = (state_q == ST_DONE) && !reset;
  assign bus.reg_count = reset ? '0 : count_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: LM/SM walks, wait states, wrap, zero mask, reset abort, ignored start.
module tb_lmsm_sequencer;

  logic clk;
  logic reset;

  lmsm_sequencer_if bus ();

  lmsm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] addr_log[$];
  logic [2:0]  idx_log[$];
  logic [2:0]  wen_log[$];
  int done_cnt, done_cyc, idle_cyc, xfer_cyc, bad_wen, bad_dir, unstable;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one operation from start; ack after wait_n stall cycles (0 = ack tied high)
  task automatic do_op(input logic st, input logic [7:0] m, input logic [15:0] b,
                       input int wait_n, input logic repulse);
    int wcnt;
    logic prev_wait;
    logic [15:0] paddr;
    logic [2:0] pidx, cidx;
    logic ack, strobe;
    addr_log.delete(); idx_log.delete(); wen_log.delete();
    done_cnt = 0; done_cyc = -1; idle_cyc = -1; xfer_cyc = 0;
    bad_wen = 0; bad_dir = 0; unstable = 0;
    wcnt = 0; prev_wait = 1'b0; paddr = '0; pidx = '0;
    bus.start = 1'b1; bus.is_store = st; bus.reg_mask = m; bus.base_addr = b;
    bus.mem_ack = (wait_n == 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 100; c++) begin
      bus.start     = repulse && (c == 1);
      bus.reg_mask  = repulse ? 8'h80 : m;
      bus.is_store  = repulse ? ~st : st;
      bus.base_addr = repulse ? 16'hBEEF : b;
      if (wait_n == 0) ack = 1'b1;
      else ack = (bus.mem_rd || bus.mem_wr) && (wcnt == wait_n);
      bus.mem_ack = ack;
      #4;
      strobe = bus.mem_rd || bus.mem_wr;
      cidx   = st ? bus.rf_raddr : bus.rf_waddr;
      if ((st && bus.mem_rd) || (!st && bus.mem_wr)) bad_dir++;
      if (strobe) begin
        xfer_cyc++;
        if (prev_wait && (bus.mem_addr != paddr || cidx != pidx)) unstable++;
        if (ack) begin
          addr_log.push_back(bus.mem_addr);
          idx_log.push_back(cidx);
          prev_wait = 1'b0; wcnt = 0;
        end else begin
          prev_wait = 1'b1; wcnt++;
        end
        paddr = bus.mem_addr; pidx = cidx;
      end else prev_wait = 1'b0;
      if (bus.rf_wen) begin
        if (!(ack && bus.mem_rd)) bad_wen++;
        wen_log.push_back(bus.rf_waddr);
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && !bus.busy && idle_cyc < 0) idle_cyc = c;
      @(posedge clk); #1;
      if (idle_cyc >= 0) break;
    end
    bus.start = 1'b0; bus.mem_ack = 1'b0;
    check_eq("op_terminates", 32'(idle_cyc >= 0), 32'd1);
  endtask

  // Compare logged accesses: address base+i (mod 2^16), index i taken from an octal-packed list
  task automatic check_xfers(input string tag, input logic [15:0] b, input int n, input logic [23:0] idx_exp);
    logic [15:0] ea;
    check_eq({tag, "_nacc"}, 32'(addr_log.size()), 32'(n));
    for (int i = 0; i < n && i < addr_log.size(); i++) begin
      ea = b + 16'(i);
      check_eq({tag, "_addr"}, 32'(addr_log[i]), 32'(ea));
      check_eq({tag, "_idx"},  32'(idx_log[i]),  32'(idx_exp[3*i +: 3]));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.is_store = 1'b0; bus.reg_mask = '0; bus.base_addr = '0; bus.mem_ack = 1'b0;
    reset = 1'b1;
    // Reset must win over a start presented at the same time
    @(posedge clk); #1;
    bus.start = 1'b1; bus.reg_mask = 8'hFF; bus.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; bus.start = 1'b0; bus.mem_ack = 1'b0;
    #4;
    check_eq("rst_busy",  32'(bus.busy),      32'd0);
    check_eq("rst_done",  32'(bus.done),      32'd0);
    check_eq("rst_rd",    32'(bus.mem_rd),    32'd0);
    check_eq("rst_wr",    32'(bus.mem_wr),    32'd0);
    check_eq("rst_addr",  32'(bus.mem_addr),  32'd0);
    check_eq("rst_count", 32'(bus.reg_count), 32'd0);
    @(posedge clk); #1;

    // LM mask A1 base 0040, zero-wait
    do_op(1'b0, 8'hA1, 16'h0040, 0, 1'b0);
    check_xfers("lm_a1", 16'h0040, 3, 24'o750);
    check_eq("lm_a1_wen_n",  32'(wen_log.size()), 32'd3);
    if (wen_log.size() == 3) begin
      check_eq("lm_a1_wen0", 32'(wen_log[0]), 32'd0);
      check_eq("lm_a1_wen1", 32'(wen_log[1]), 32'd5);
      check_eq("lm_a1_wen2", 32'(wen_log[2]), 32'd7);
    end
    check_eq("lm_a1_badwen", 32'(bad_wen),  32'd0);
    check_eq("lm_a1_dir",    32'(bad_dir),  32'd0);
    check_eq("lm_a1_done_c", 32'(done_cyc), 32'd4);
    check_eq("lm_a1_done_n", 32'(done_cnt), 32'd1);
    check_eq("lm_a1_idle_c", 32'(idle_cyc), 32'd5);
    repeat (2) @(posedge clk);
    #5 check_eq("lm_a1_count_hold", 32'(bus.reg_count), 32'd3);
    @(posedge clk); #1;

    // SM mask FF base FFFE, address wraps
    do_op(1'b1, 8'hFF, 16'hFFFE, 0, 1'b0);
    check_xfers("sm_ff", 16'hFFFE, 8, 24'o76543210);
    check_eq("sm_ff_xfer",  32'(xfer_cyc),         32'd8);
    check_eq("sm_ff_wen",   32'(wen_log.size()),   32'd0);
    check_eq("sm_ff_dir",   32'(bad_dir),          32'd0);
    check_eq("sm_ff_done",  32'(done_cyc),         32'd9);
    check_eq("sm_ff_count", 32'(bus.reg_count),    32'd8);

    // Zero mask: straight to DONE
    do_op(1'b0, 8'h00, 16'h1111, 0, 1'b0);
    check_eq("z_xfer",  32'(xfer_cyc),      32'd0);
    check_eq("z_done",  32'(done_cyc),      32'd1);
    check_eq("z_idle",  32'(idle_cyc),      32'd2);
    check_eq("z_count", 32'(bus.reg_count), 32'd0);

    // LM mask 06 with three stall cycles per access
    do_op(1'b0, 8'h06, 16'h1234, 3, 1'b0);
    check_xfers("lm_w", 16'h1234, 2, 24'o21);
    check_eq("lm_w_xfer",   32'(xfer_cyc),       32'd8);
    check_eq("lm_w_stable", 32'(unstable),       32'd0);
    check_eq("lm_w_badwen", 32'(bad_wen),        32'd0);
    check_eq("lm_w_wen_n",  32'(wen_log.size()), 32'd2);
    if (wen_log.size() == 2) begin
      check_eq("lm_w_wen0", 32'(wen_log[0]), 32'd1);
      check_eq("lm_w_wen1", 32'(wen_log[1]), 32'd2);
    end
    check_eq("lm_w_done", 32'(done_cyc), 32'd9);

    // Start re-pulsed mid-operation is ignored
    do_op(1'b0, 8'h03, 16'h0010, 0, 1'b1);
    check_xfers("rp", 16'h0010, 2, 24'o10);
    check_eq("rp_dir",    32'(bad_dir),       32'd0);
    check_eq("rp_done_n", 32'(done_cnt),      32'd1);
    check_eq("rp_count",  32'(bus.reg_count), 32'd2);

    // SM mask FF aborted by reset after the second ack
    bus.start = 1'b1; bus.is_store = 1'b1; bus.reg_mask = 8'hFF; bus.base_addr = 16'h0200; bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    #4 check_eq("ra_c1_wr", 32'(bus.mem_wr), 32'd1);
    @(posedge clk); #1;
    #4 check_eq("ra_c2_addr", 32'(bus.mem_addr), 32'h0201);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #4;
    check_eq("ra_busy",  32'(bus.busy),      32'd0);
    check_eq("ra_wr",    32'(bus.mem_wr),    32'd0);
    check_eq("ra_rd",    32'(bus.mem_rd),    32'd0);
    check_eq("ra_wen",   32'(bus.rf_wen),    32'd0);
    check_eq("ra_done",  32'(bus.done),      32'd0);
    check_eq("ra_count", 32'(bus.reg_count), 32'd0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    do_op(1'b1, 8'h01, 16'h0300, 0, 1'b0);
    check_xfers("ra_new", 16'h0300, 1, 24'o0);
    check_eq("ra_new_done",  32'(done_cyc),      32'd2);
    check_eq("ra_new_count", 32'(bus.reg_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
Sequencer for the Load-Multiple / Store-Multiple instructions of the multicycle processor. The main controller hands over a register mask and base address. This block then walks the set mask bits lowest-first and issues one memory access per selected register. For LM it drives register-file writes; for SM it drives register-file reads. It sits beside the controller and steers the datapath's memory address, memory strobes and register-file address/enable muxes while busy.

Parameters:
NREG, 8, number of architectural registers (mask width)
AW, 16, memory address width
RW, 3, register index width (log2 NREG)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request from main controller; accepted only in IDLE
is_store  in  1  1 = SM (register to memory), 0 = LM (memory to register); sampled with start
reg_mask  in  NREG  IR[7:0]; bit i selects register Ri; sampled with start
base_addr  in  AW  contents of RA; sampled with start
mem_ack  in  1  memory completes the current access this cycle
mem_addr  out  AW  address of the current access
mem_rd  out  1  read strobe (LM)
mem_wr  out  1  write strobe (SM)
rf_raddr  out  RW  register index to read for SM data
rf_waddr  out  RW  register index to write for LM data
rf_wen  out  1  register-file write enable (LM, on ack cycle only)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
reg_count  out  RW+1  number of registers transferred by the last/current operation

Behaviour:
- States: IDLE, XFER, DONE (2-bit encoding). busy = (state != IDLE).
- Reset: state IDLE; remaining mask, addr register, reg_count and latched is_store all cleared. Every output is 0 while in reset and in IDLE.
- Reset has priority over every other input, including start in the same cycle.
- IDLE + start: latch reg_mask, base_addr, is_store; clear reg_count.
  - Mask nonzero: go to XFER.
  - Mask zero: go to DONE (no memory access).
- Current index = lowest set bit of the remaining mask (combinational priority encoder).
- XFER outputs:
  - mem_addr = addr register.
  - mem_rd = !is_store; mem_wr = is_store.
  - rf_raddr = rf_waddr = current index.
  - All of these are held stable until mem_ack.
- XFER + mem_ack:
  - rf_wen = !is_store in that same cycle.
  - Next edge: clear the current mask bit, addr += 1, reg_count += 1.
  - If the cleared mask becomes zero, go to DONE; otherwise stay in XFER for the next register. Back-to-back transfers take no bubble cycle.
- XFER without mem_ack: wait; no state change, no rf_wen.
- DONE: done = 1 for exactly one cycle; strobes 0; go to IDLE.
- Address arithmetic is modulo 2^AW: 0xFFFF + 1 wraps to 0x0000.
- Latency with a k-bit mask and zero-wait memory, start sampled at edge T:
  - XFER cycles T+1 .. T+k.
  - done high in cycle T+k+1.
  - busy low from T+k+2.
- Ignored inputs:
  - start while busy, with no effect on the latched operands.
  - mem_ack outside XFER.
- Base register included in the LM mask: the write proceeds normally; the address is unaffected because base_addr was latched at start.
- Reset mid-operation: the in-flight access is abandoned and the strobes are low from the next cycle. No done pulse. A new start is accepted in the cycle after reset deasserts.
- reg_count holds its final value after DONE until the next accepted start.

Decomposition:
- Shared package holds:
  - State encoding localparams (ST_IDLE = 0, ST_XFER = 1, ST_DONE = 2).
  - NREG, AW, RW constants.
  - LM/SM opcode values used by the main controller to raise start.
- One sub-module: prio_enc_lsb, a NREG-bit lowest-set-bit encoder with outputs index[RW-1:0] and valid.

Test Plan:
- LM, mask 8'b1010_0001, base 0x0040, mem_ack tied 1 -> mem_rd at addresses 0x0040, 0x0041, 0x0042; rf_waddr 0, 5, 7 with one rf_wen each; done at start+4; reg_count = 3.
- SM, mask 0xFF, base 0xFFFE, ack tied 1 -> addresses FFFE, FFFF, 0000 .. 0005; rf_raddr 0 .. 7; 8 mem_wr cycles; rf_wen never high; reg_count = 8.
- Mask 0x00 -> no mem_rd/mem_wr; done one cycle after start; reg_count = 0; busy low two cycles after start.
- LM, mask 0x06, mem_ack delayed 3 cycles per access -> mem_addr/rf_waddr/mem_rd steady across wait cycles; rf_wen only on ack cycles (index 1 then 2); done after 8 XFER cycles.
- SM, mask 0xFF, reset asserted after the 2nd ack -> next cycle busy = 0, all strobes 0, no done; a following start with mask 0x01 completes normally.
- start re-pulsed with mask 0x80 during an LM with mask 0x03 -> ignored; only registers 0 and 1 are transferred, and exactly one done pulse occurs.
